// File: rtl/writeback.sv
// Writeback stage: owns the architectural register file, two async read ports and a retire counter.
// Optional macro WB_BYPASS_EN forwards the pending write onto the read ports.
module writeback #(
  parameter int unsigned WORD     = 32,
  parameter int unsigned W_RD     = 5,
  parameter int unsigned W_CNT    = 32,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             v_i,
  output logic             stall_o,
  input  logic [W_RD-1:0]  rd_num_i,
  input  logic             wb_i,
  input  logic [WORD-1:0]  rd_data_i,
  input  logic             hold_i,
  input  logic [W_RD-1:0]  rs_num_i,
  input  logic [W_RD-1:0]  rt_num_i,
  output logic [WORD-1:0]  rs_data_o,
  output logic [WORD-1:0]  rt_data_o,
  output logic [W_CNT-1:0] retired_o
);

  localparam int unsigned NREG = 1 << W_RD;

  logic             v_q;
  logic [W_RD-1:0]  rd_num_q;
  logic             wb_q;
  logic [WORD-1:0]  rd_data_q;
  logic [WORD-1:0]  regs_q [NREG];
  logic [W_CNT-1:0] retired_q;

  logic load, retire, rd_legal, we;
  logic rs_zero, rt_zero;
  logic [WORD-1:0] rs_base, rt_base;

  // An empty stage always accepts, even while held.
  assign load     = ~hold_i | ~v_q;
  assign retire   = v_q & ~hold_i;
  assign rd_legal = !((ZERO_REG != 0) && (rd_num_q == '0));
  assign we       = retire & wb_q & rd_legal;
  assign stall_o  = v_q & hold_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q       <= 1'b0;
      rd_num_q  <= '0;
      wb_q      <= 1'b0;
      rd_data_q <= '0;
      retired_q <= '0;
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      if (load) begin
        v_q       <= v_i;
        rd_num_q  <= rd_num_i;
        wb_q      <= wb_i;
        rd_data_q <= rd_data_i;
      end
      if (we) begin
        regs_q[rd_num_q] <= rd_data_q;
      end
      if (retire) begin
        retired_q <= retired_q + W_CNT'(1);
      end
    end
  end

  assign retired_o = retired_q;

  assign rs_zero = (ZERO_REG != 0) && (rs_num_i == '0);
  assign rt_zero = (ZERO_REG != 0) && (rt_num_i == '0);
  assign rs_base = rs_zero ? '0 : regs_q[rs_num_i];
  assign rt_base = rt_zero ? '0 : regs_q[rt_num_i];

`ifdef WB_BYPASS_EN
  logic pend;
  // Forward whatever sits in the stage, held or not, as long as it will really write.
  assign pend = v_q & wb_q & rd_legal;

  always_comb begin
    rs_data_o = rs_base;
    rt_data_o = rt_base;
    if (pend && (rs_num_i == rd_num_q)) rs_data_o = rd_data_q;
    if (pend && (rt_num_i == rd_num_q)) rt_data_o = rd_data_q;
  end
`else
  always_comb begin
    rs_data_o = rs_base;
    rt_data_o = rt_base;
  end
`endif

endmodule

// File: tb/tb_writeback.sv
// Randomised and directed bench for writeback; two instances (32-bit counter with r0 hardwired,
// 4-bit counter with r0 ordinary) share stimulus and are checked against one behavioural model.
module tb_writeback;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        v = 1'b0, wb = 1'b0, hold = 1'b0;
  logic [4:0]  rd = '0, rs = '0, rt = '0;
  logic [31:0] data = '0;

  logic        stall, stall4;
  logic [31:0] rs_data, rt_data, rs_data4, rt_data4, retired;
  logic [3:0]  retired4;

  int vectors = 0;
  int fails   = 0;

  // Model: pending stage entry plus two register images and an unbounded retire count.
  bit          pv, pwb;
  logic [4:0]  prd;
  logic [31:0] pdata;
  logic [31:0] m32 [32];
  logic [31:0] m4  [32];
  logic [31:0] cnt;

  always #5 clk = ~clk;

  writeback dut (
    .clk(clk), .rst(rst), .v_i(v), .stall_o(stall), .rd_num_i(rd), .wb_i(wb),
    .rd_data_i(data), .hold_i(hold), .rs_num_i(rs), .rt_num_i(rt),
    .rs_data_o(rs_data), .rt_data_o(rt_data), .retired_o(retired)
  );

  writeback #(.W_CNT(4), .ZERO_REG(0)) dut4 (
    .clk(clk), .rst(rst), .v_i(v), .stall_o(stall4), .rd_num_i(rd), .wb_i(wb),
    .rd_data_i(data), .hold_i(hold), .rs_num_i(rs), .rt_num_i(rt),
    .rs_data_o(rs_data4), .rt_data_o(rt_data4), .retired_o(retired4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mread(input bit zero_reg, input logic [4:0] idx);
    if (zero_reg && idx == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
    if (pv && pwb && idx == prd) return pdata;
`endif
    return zero_reg ? m32[idx] : m4[idx];
  endfunction

  task automatic model_clear();
    pv = 1'b0; pwb = 1'b0; prd = '0; pdata = '0; cnt = '0;
    for (int i = 0; i < 32; i++) begin
      m32[i] = '0;
      m4[i]  = '0;
    end
  endtask

  task automatic model_edge();
    if (pv && !hold) begin
      cnt = cnt + 1;
      if (pwb) begin
        if (prd != 5'd0) m32[prd] = pdata;
        m4[prd] = pdata;
      end
    end
    if (!hold || !pv) begin
      pv = v; pwb = wb; prd = rd; pdata = data;
    end
  endtask

  task automatic check_all();
    chk("stall",     32'(stall),    32'(pv & hold));
    chk("stall4",    32'(stall4),   32'(pv & hold));
    chk("rs_data",   rs_data,       mread(1'b1, rs));
    chk("rt_data",   rt_data,       mread(1'b1, rt));
    chk("rs_data4",  rs_data4,      mread(1'b0, rs));
    chk("rt_data4",  rt_data4,      mread(1'b0, rt));
    chk("retired",   retired,       cnt);
    chk("retired4",  32'(retired4), cnt & 32'd15);
  endtask

  // Called at a negedge: drive, check combinational outputs, take one edge, return at negedge.
  task automatic cyc(input logic v_, input logic wb_, input logic [4:0] rd_,
                     input logic [31:0] data_, input logic hold_,
                     input logic [4:0] rs_, input logic [4:0] rt_);
    v = v_; wb = wb_; rd = rd_; data = data_; hold = hold_; rs = rs_; rt = rt_;
    #1;
    check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_clear();
    check_all();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    model_clear();
    @(negedge clk);
    // Reset
    rs = 5'd7; rt = 5'd7;
    do_reset();
    cyc(0, 0, 0, 0, 0, 7, 7);

    // Single write to r3
    cyc(1, 1, 3, 32'hDEADBEEF, 0, 3, 3);
    cyc(0, 0, 0, 0, 0, 3, 3);
    cyc(0, 0, 0, 0, 0, 3, 3);
    chk("r3_direct", rs_data, 32'hDEADBEEF);

    // Write to r0: discarded on the ZERO_REG instance, kept on the other
    cyc(1, 1, 0, 32'h55, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Held valid entry, then release
    cyc(1, 1, 9, 32'hA5A5A5A5, 0, 9, 3);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 9, 3);
    cyc(0, 0, 0, 0, 0, 9, 3);
    cyc(0, 0, 0, 0, 0, 9, 3);

    // Bubble under hold: accepts and does not stall
    cyc(0, 0, 0, 0, 1, 10, 9);
    cyc(1, 1, 10, 32'h77, 1, 10, 9);
    cyc(0, 0, 0, 0, 1, 10, 9);
    cyc(0, 0, 0, 0, 0, 10, 9);
    cyc(0, 0, 0, 0, 0, 10, 9);

    // Pending write visible (or not) on the read port
    cyc(1, 1, 5, 32'h1234, 0, 5, 5);
    cyc(0, 0, 0, 0, 0, 5, 5);
    cyc(0, 0, 0, 0, 0, 5, 5);

    // Back-to-back writes to the same register
    cyc(1, 1, 12, 32'h1, 0, 12, 12);
    cyc(1, 1, 12, 32'h2, 0, 12, 12);
    cyc(0, 0, 0, 0, 0, 12, 12);
    cyc(0, 0, 0, 0, 0, 12, 12);

    // Counter wrap on the 4-bit instance
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1, 0, 4, 32'hFFFF, 0, 4, 0);
    cyc(0, 0, 0, 0, 0, 4, 0);
    chk("wrap4", 32'(retired4), 32'd0);

    // Reset while a valid entry is held
    cyc(1, 1, 14, 32'hCAFE, 0, 14, 0);
    cyc(0, 0, 0, 0, 1, 14, 0);
    #2;
    rst = 1'b0;
    #1;
    model_clear();
    check_all();
    @(negedge clk);
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0, 14, 0);
    cyc(0, 0, 0, 0, 0, 14, 0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(3) != 0), 1'($urandom), 5'($urandom), $urandom,
          ($urandom_range(3) == 0), 5'($urandom), 5'($urandom));
    end
    cyc(0, 0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
